button_event_decoder: RTL and testbench

- Consumes the conditioned button stream (debounced level plus single-cycle p_edge/n_edge pulses) produced by the button conditioning front end.
- Turns that stream into game-level events: a fire pulse on press and auto-repeat fire while held, short/long release classification, double-click detection, and a running shot counter.
- Sits between the joystick/button interface and the sprite/shot logic in the video top.

---
 rtl/button_event_decoder.sv | 152 +++++++++++++++
 tb/tb_button_event_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Game-level button event decoder: press/auto-repeat fire, short/long release,
// double-click detection and a wrapping shot counter, all outputs registered.
module button_event_decoder #(
    parameter int DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int DC_WINDOW     = 30_000_000,
    parameter int CNT_W         = 32,
    parameter int SHOT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              level,
    input  logic              p_edge,
    input  logic              n_edge,
    output logic              fire,
    output logic              short_release,
    output logic              long_release,
    output logic              double_click,
    output logic              held,
    output logic [SHOT_W-1:0] shot_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HELD   = 2'b01,
        REPEAT = 2'b10,
        GAP    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_TERM  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DC_TERM     = CNT_W'(DC_WINDOW - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   timer_r;
    logic [CNT_W-1:0]   timer_nxt_s;
    logic [SHOT_W-1:0]  shot_count_r;
    logic               fire_r;
    logic               short_release_r;
    logic               long_release_r;
    logic               double_click_r;
    logic               held_r;
    logic               fire_nxt_s;
    logic               short_release_nxt_s;
    logic               long_release_nxt_s;
    logic               double_click_nxt_s;
    logic               held_nxt_s;
    logic               release_s;

    // A low level also counts as release so a lost n_edge cannot leave us stuck held.
    assign release_s = n_edge | ~level;

    // Next-state, timer and event decode.
    always_comb begin
        state_nxt_s         = state_r;
        timer_nxt_s         = timer_r;
        fire_nxt_s          = 1'b0;
        short_release_nxt_s = 1'b0;
        long_release_nxt_s  = 1'b0;
        double_click_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (p_edge) begin
                    fire_nxt_s  = 1'b1;
                    state_nxt_s = HELD;
                    timer_nxt_s = {CNT_W{1'b0}};
                end else begin
                    timer_nxt_s = {CNT_W{1'b0}};
                end
            end
            HELD: begin
                if (release_s) begin
                    short_release_nxt_s = 1'b1;
                    state_nxt_s         = GAP;
                    timer_nxt_s         = {CNT_W{1'b0}};
                end else if (timer_r == DELAY_TERM) begin
                    fire_nxt_s  = 1'b1;
                    state_nxt_s = REPEAT;
                    timer_nxt_s = {CNT_W{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (release_s) begin
                    long_release_nxt_s = 1'b1;
                    state_nxt_s        = IDLE;
                    timer_nxt_s        = {CNT_W{1'b0}};
                end else if (timer_r == REPEAT_TERM) begin
                    fire_nxt_s  = 1'b1;
                    timer_nxt_s = {CNT_W{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + CNT_W'(1);
                end
            end
            GAP: begin
                if (p_edge) begin
                    fire_nxt_s         = 1'b1;
                    double_click_nxt_s = 1'b1;
                    state_nxt_s        = HELD;
                    timer_nxt_s        = {CNT_W{1'b0}};
                end else if (timer_r == DC_TERM) begin
                    state_nxt_s = IDLE;
                    timer_nxt_s = {CNT_W{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                timer_nxt_s = {CNT_W{1'b0}};
            end
        endcase
        held_nxt_s = (state_nxt_s == HELD) || (state_nxt_s == REPEAT);
    end

    // State, timer, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= IDLE;
            timer_r         <= {CNT_W{1'b0}};
            shot_count_r    <= {SHOT_W{1'b0}};
            fire_r          <= 1'b0;
            short_release_r <= 1'b0;
            long_release_r  <= 1'b0;
            double_click_r  <= 1'b0;
            held_r          <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            timer_r         <= timer_nxt_s;
            fire_r          <= fire_nxt_s;
            short_release_r <= short_release_nxt_s;
            long_release_r  <= long_release_nxt_s;
            double_click_r  <= double_click_nxt_s;
            held_r          <= held_nxt_s;
            if (fire_nxt_s) begin
                shot_count_r <= shot_count_r + SHOT_W'(1);
            end else begin
                shot_count_r <= shot_count_r;
            end
        end
    end

    assign fire          = fire_r;
    assign short_release = short_release_r;
    assign long_release  = long_release_r;
    assign double_click  = double_click_r;
    assign held          = held_r;
    assign shot_count    = shot_count_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed self-checking bench for button_event_decoder with small timing parameters.
module tb_button_event_decoder;

    logic       clk;
    logic       reset;
    logic       level;
    logic       p_edge;
    logic       n_edge;
    logic       fire;
    logic       short_release;
    logic       long_release;
    logic       double_click;
    logic       held;
    logic [7:0] shot_count;

    int errors;
    int checks;

    button_event_decoder #(
        .DELAY_CYCLES (8),
        .REPEAT_CYCLES(4),
        .DC_WINDOW    (6),
        .CNT_W        (8),
        .SHOT_W       (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .level        (level),
        .p_edge       (p_edge),
        .n_edge       (n_edge),
        .fire         (fire),
        .short_release(short_release),
        .long_release (long_release),
        .double_click (double_click),
        .held         (held),
        .shot_count   (shot_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input cycle; afterwards the outputs caused by it are visible.
    task automatic step(input logic l, input logic p, input logic n);
        level  = l;
        p_edge = p;
        n_edge = n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if ({fire, short_release, long_release, double_click, held} !== 5'b00000
                || shot_count !== 8'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b%b%b%b%b cnt=%0d want=00000 cnt=0",
                         i, fire, short_release, long_release, double_click, held, shot_count);
            end
        end
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (fire !== 1'b1 || held !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_press got fire=%b held=%b want 1 1", fire, held);
        end
    endtask

    task automatic test_auto_repeat();
        logic exp_fire;
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (fire !== 1'b1) begin
            errors++;
            $display("FAIL repeat_press_fire got=%b want=1", fire);
        end
        for (int k = 1; k < 20; k++) begin
            step(1'b1, 1'b0, 1'b0);
            exp_fire = (k == 8 || k == 12 || k == 16) ? 1'b1 : 1'b0;
            checks++;
            if (fire !== exp_fire) begin
                errors++;
                $display("FAIL repeat_fire at t+%0d got=%b want=%b", k + 1, fire, exp_fire);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (long_release !== 1'b1 || held !== 1'b0 || fire !== 1'b0 || short_release !== 1'b0) begin
            errors++;
            $display("FAIL repeat_long_release got lr=%b held=%b fire=%b sr=%b want 1 0 0 0",
                     long_release, held, fire, short_release);
        end
        checks++;
        if (shot_count !== 8'd4) begin
            errors++;
            $display("FAIL repeat_shot_count got=%0d want=4", shot_count);
        end
    endtask

    task automatic test_release_at_terminal();
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (short_release !== 1'b1 || fire !== 1'b0 || long_release !== 1'b0 || held !== 1'b0) begin
            errors++;
            $display("FAIL terminal_release got sr=%b fire=%b lr=%b held=%b want 1 0 0 0",
                     short_release, fire, long_release, held);
        end
        checks++;
        if (shot_count !== 8'd1) begin
            errors++;
            $display("FAIL terminal_shot_count got=%0d want=1", shot_count);
        end
    endtask

    task automatic test_double_click(input int second_press, input logic exp_dc);
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (short_release !== 1'b1 || held !== 1'b0) begin
            errors++;
            $display("FAIL dc_short_release got sr=%b held=%b want 1 0", short_release, held);
        end
        for (int k = 4; k < second_press; k++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (fire !== 1'b1 || double_click !== exp_dc || short_release !== 1'b0) begin
            errors++;
            $display("FAIL dc_second_press t+%0d got fire=%b dc=%b sr=%b want 1 %b 0",
                     second_press, fire, double_click, short_release, exp_dc);
        end
        checks++;
        if (shot_count !== 8'd2) begin
            errors++;
            $display("FAIL dc_shot_count got=%0d want=2", shot_count);
        end
    endtask

    task automatic test_missed_n_edge();
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 5; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (short_release !== 1'b1 || held !== 1'b0) begin
            errors++;
            $display("FAIL missed_nedge_release got sr=%b held=%b want 1 0", short_release, held);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (double_click !== 1'b1 || fire !== 1'b1) begin
            errors++;
            $display("FAIL missed_nedge_gap got dc=%b fire=%b want 1 1", double_click, fire);
        end
    endtask

    task automatic test_wrap_and_reset_abort();
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (fire !== 1'b0 || short_release !== 1'b0 || long_release !== 1'b0) begin
            errors++;
            $display("FAIL idle_nedge_ignored got fire=%b sr=%b lr=%b want 0 0 0",
                     fire, short_release, long_release);
        end
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (shot_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_preload got=%0d want=255", shot_count);
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (shot_count !== 8'd0 || fire !== 1'b1) begin
            errors++;
            $display("FAIL wrap_to_zero got cnt=%0d fire=%b want cnt=0 fire=1", shot_count, fire);
        end
        for (int k = 1; k < 10; k++) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (shot_count !== 8'd1 || held !== 1'b1) begin
            errors++;
            $display("FAIL wrap_in_repeat got cnt=%0d held=%b want cnt=1 held=1", shot_count, held);
        end
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        checks++;
        if (long_release !== 1'b0 || held !== 1'b0 || fire !== 1'b0 || shot_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_abort got lr=%b held=%b fire=%b cnt=%0d want 0 0 0 0",
                     long_release, held, fire, shot_count);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (long_release !== 1'b0 || short_release !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_after got lr=%b sr=%b want 0 0", long_release, short_release);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        level  = 1'b0;
        p_edge = 1'b0;
        n_edge = 1'b0;
        test_reset();
        test_auto_repeat();
        test_release_at_terminal();
        test_double_click(8, 1'b1);
        test_double_click(10, 1'b0);
        test_missed_n_edge();
        test_wrap_and_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
